// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle redirect flushes,
// memory-busy freeze, stall/flush performance counters and a busy watchdog.
module hazard_stall_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        ex_jump,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        mem_timeout
);

    localparam int unsigned FCW  = 4;
    localparam int unsigned BCW  = 8;
    localparam int unsigned CNTW = 16;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
    logic [BCW-1:0]  busy_cnt_q, busy_cnt_d;
    logic [CNTW-1:0] stall_cycles_q, flush_count_q;
    logic            mem_timeout_q;
    logic            flush_evt;
    logic            load_use;
    logic            redirect;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign redirect = ex_branch_taken || ex_jump;

    // Mealy output decode and next-state; mem_busy outranks everything but reset
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        flush_evt    = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
        end else if (state_q == ST_FLUSH) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            if (flush_cnt_q <= FCW'(1)) begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end else begin
                flush_cnt_d = flush_cnt_q - FCW'(1);
            end
        end else if (redirect) begin
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
            flush_evt    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
            end
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Watchdog counter saturates at the timeout threshold
    always_comb begin
        busy_cnt_d = '0;
        if (mem_busy) begin
            if (busy_cnt_q < BCW'(MEM_TIMEOUT)) begin
                busy_cnt_d = busy_cnt_q + BCW'(1);
            end else begin
                busy_cnt_d = busy_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            flush_cnt_q    <= '0;
            busy_cnt_q     <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
            if (!pc_write && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + CNTW'(1);
            end
            if (flush_evt && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + CNTW'(1);
            end
            if (busy_cnt_d == BCW'(MEM_TIMEOUT)) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=4.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        ex_jump;
    logic        mem_busy;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_write;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
    logic        mem_timeout;

    int errors = 0;
    int checks = 0;

    hazard_stall_ctrl #(
        .FLUSH_CYCLES(3),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .ex_jump        (ex_jump),
        .mem_busy       (mem_busy),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .mem_timeout    (mem_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Control vector order: {pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rd = '0; ex_branch_taken = 1'b0;
        ex_jump = 1'b0; mem_busy = 1'b0;

        // Reset held for two posedges, then released idle
        @(negedge clk); #1 chk_ctl("rst_ctl", 5'b00011);
        @(negedge clk); rst_n = 1'b1;
        #1 chk_ctl("run_idle", 5'b11100);
        chk("rst_stall", stall_cycles, 16'd0);
        chk("rst_flush", flush_count, 16'd0);
        chk("rst_wd", 16'(mem_timeout), 16'd0);

        // Load-use on rs, then ex_rd=0, then rt used / unused
        @(negedge clk); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        #1 chk_ctl("lu_rs", 5'b00110);
        @(negedge clk); ex_rd = 5'd0; id_rs = 5'd0;
        #1 chk_ctl("lu_rd0", 5'b11100);
        chk("stall_1", stall_cycles, 16'd1);
        @(negedge clk); ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3;
        #1 chk_ctl("lu_rt", 5'b00110);
        @(negedge clk); id_uses_rt = 1'b0;
        #1 chk_ctl("rt_unused", 5'b11100);
        chk("stall_2", stall_cycles, 16'd2);

        // Taken branch: three flush cycles, redirect ignored inside FLUSH
        @(negedge clk); ex_mem_read = 1'b0; ex_rd = '0; id_rt = '0; id_rs = '0;
        ex_branch_taken = 1'b1;
        #1 chk_ctl("br_accept", 5'b11111);
        @(negedge clk); ex_branch_taken = 1'b0; ex_jump = 1'b1;
        #1 chk_ctl("br_flush1", 5'b01111);
        chk("br_fcount", flush_count, 16'd1);
        @(negedge clk); ex_jump = 1'b0;
        #1 chk_ctl("br_flush2", 5'b01111);
        @(negedge clk);
        #1 chk_ctl("br_back_run", 5'b11100);
        chk("br_fcount_hold", flush_count, 16'd1);
        chk("br_stall", stall_cycles, 16'd4);

        // Jump together with load-use: redirect wins
        @(negedge clk); ex_jump = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        #1 chk_ctl("jmp_over_lu", 5'b11111);
        @(negedge clk); ex_jump = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; id_rs = '0;
        #1 chk_ctl("jmp_flush1", 5'b01111);
        chk("jmp_fcount", flush_count, 16'd2);
        @(negedge clk);
        @(negedge clk);
        #1 chk_ctl("jmp_back_run", 5'b11100);
        chk("jmp_stall", stall_cycles, 16'd6);

        // Fresh reset, then mem_busy for 4 cycles with a pending branch
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rst2_stall", stall_cycles, 16'd0);
        mem_busy = 1'b1; ex_branch_taken = 1'b1;
        #1 chk_ctl("busy_0", 5'b00000);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            #1 chk_ctl("busy_n", 5'b00000);
            chk("busy_wd_low", 16'(mem_timeout), 16'd0);
        end
        @(negedge clk); mem_busy = 1'b0;
        #1 chk_ctl("busy_accept", 5'b11111);
        chk("busy_wd_set", 16'(mem_timeout), 16'd1);
        chk("busy_fcount0", flush_count, 16'd0);
        chk("busy_stall", stall_cycles, 16'd4);
        @(negedge clk); ex_branch_taken = 1'b0;
        #1 chk_ctl("busy_flush1", 5'b01111);
        chk("busy_fcount1", flush_count, 16'd1);

        // Reset mid-FLUSH returns to RUN with cleared counters
        @(negedge clk); rst_n = 1'b0;
        #1 chk_ctl("rst_midflush", 5'b00011);
        @(negedge clk); rst_n = 1'b1;
        #1 chk_ctl("after_rst_run", 5'b11100);
        chk("after_rst_stall", stall_cycles, 16'd0);
        chk("after_rst_fcount", flush_count, 16'd0);
        chk("after_rst_wd", 16'(mem_timeout), 16'd0);

        // Watchdog: busy six cycles, sticky after busy drops
        mem_busy = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #1 chk("wd_step", 16'(mem_timeout), 16'(i >= 4));
        end
        mem_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("wd_sticky", 16'(mem_timeout), 16'd1);
        end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1 chk("wd_cleared", 16'(mem_timeout), 16'd0);

        // Hold a load-use stall long enough to saturate stall_cycles
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        repeat (70000) @(negedge clk);
        #1 chk("stall_sat", stall_cycles, 16'hFFFF);
        chk_ctl("sat_ctl", 5'b00110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
